traffic_density_estimator: RTL and testbench

TRAFFIC_DENSITY_ESTIMATOR -- requirements
Module: traffic_density_estimator

---
 rtl/traffic_pkg.sv | 35 +++
 rtl/traffic_lane_counter.sv | 61 ++++++
 rtl/traffic_density_estimator.sv | 74 +++++++
 tb/tb_traffic_density_estimator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared level encodings, default tuning values and the window-end level decision
// used by the lane counters and the downstream signal controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    LVL_LOW  = 2'b00,
    LVL_MED  = 2'b01,
    LVL_HIGH = 2'b10
  } level_e;

  localparam int WINDOW_CYCLES_DEF = 30;
  localparam int TH_MED_DEF        = 4;
  localparam int TH_HIGH_DEF       = 10;
  localparam int HYST_DEF          = 1;
  localparam int STUCK_CYCLES_DEF  = 16;

  localparam int CNT_W = 8;
  localparam int STK_W = 5;

  // Upgrades are immediate; downgrades need the count to drop HYST below the threshold.
  function automatic level_e next_level(input logic [CNT_W-1:0] c, input level_e cur,
                                        input logic fault, input int th_med,
                                        input int th_high, input int hyst);
    int     ci;
    level_e res;
    ci = int'(c);
    if (fault || ci >= th_high)                        res = LVL_HIGH;
    else if (cur == LVL_HIGH && ci >= th_high - hyst)  res = LVL_HIGH;
    else if (ci >= th_med)                             res = LVL_MED;
    else if (cur != LVL_LOW && ci >= th_med - hyst)    res = LVL_MED;
    else                                               res = LVL_LOW;
    return res;
  endfunction

endpackage

// File: rtl/traffic_lane_counter.sv
// One lane: detector synchronizer, rising-edge count per window, stuck-high
// watchdog and the registered density level.
module traffic_lane_counter
  import traffic_pkg::*;
#(
  parameter int TH_MED       = TH_MED_DEF,
  parameter int TH_HIGH      = TH_HIGH_DEF,
  parameter int HYST         = HYST_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_i,
  input  logic       win_end_i,
  output logic [1:0] level_o,
  output logic       fault_o
);

  localparam logic [STK_W-1:0] STK_LIM = STK_W'(STUCK_CYCLES);

  logic [2:0]       sync_q;      // [0],[1] synchronizer, [2] previous value for edge detect
  logic [2:0]       vld_pipe_q;  // marks when sync_q holds post-reset samples
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic [STK_W-1:0] stk_q, stk_d;
  level_e           lvl_q, lvl_d;
  logic             fault_q, fault_d;
  logic             edge_det;

  // Gating on vld_pipe keeps an input already high at reset release from counting.
  assign edge_det = sync_q[1] & ~sync_q[2] & vld_pipe_q[2];

  always_comb begin
    cnt_eff = (edge_det && cnt_q != '1) ? cnt_q + 8'd1 : cnt_q;
    cnt_d   = win_end_i ? '0 : cnt_eff;
    lvl_d   = win_end_i ? next_level(cnt_eff, lvl_q, fault_q, TH_MED, TH_HIGH, HYST) : lvl_q;
    stk_d   = !sync_q[1] ? '0 : (stk_q == '1) ? stk_q : stk_q + 5'd1;
    fault_d = sync_q[1] && (stk_q >= STK_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      vld_pipe_q <= '0;
      cnt_q      <= '0;
      stk_q      <= '0;
      lvl_q      <= LVL_LOW;
      fault_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], car_i};
      vld_pipe_q <= {vld_pipe_q[1:0], 1'b1};
      cnt_q      <= cnt_d;
      stk_q      <= stk_d;
      lvl_q      <= lvl_d;
      fault_q    <= fault_d;
    end
  end

  assign level_o = lvl_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/traffic_density_estimator.sv
// Three-lane traffic density estimator: shared measurement window, one lane
// counter per detector, and a strobe marking each level update.
module traffic_density_estimator
  import traffic_pkg::*;
#(
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int TH_MED        = TH_MED_DEF,
  parameter int TH_HIGH       = TH_HIGH_DEF,
  parameter int HYST          = HYST_DEF,
  parameter int STUCK_CYCLES  = STUCK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_A,
  input  logic       car_B,
  input  logic       car_C,
  output logic [1:0] traffic_A,
  output logic [1:0] traffic_B,
  output logic [1:0] traffic_C,
  output logic       level_valid,
  output logic       fault_A,
  output logic       fault_B,
  output logic       fault_C
);

  localparam int NUM_LANES = 3;
  localparam int WIN_W     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  logic [WIN_W-1:0]            win_q, win_d;
  logic                        win_end;
  logic                        valid_q;
  logic [NUM_LANES-1:0]        car_vec, fault_vec;
  logic [NUM_LANES-1:0][1:0]   lvl_vec;

  assign win_end = (win_q == WIN_W'(WINDOW_CYCLES - 1));
  assign win_d   = win_end ? '0 : win_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      valid_q <= win_end;
    end
  end

  assign car_vec = {car_C, car_B, car_A};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    traffic_lane_counter #(
      .TH_MED       (TH_MED),
      .TH_HIGH      (TH_HIGH),
      .HYST         (HYST),
      .STUCK_CYCLES (STUCK_CYCLES)
    ) u_lane (
      .clk       (clk),
      .rst_n     (reset),
      .car_i     (car_vec[g]),
      .win_end_i (win_end),
      .level_o   (lvl_vec[g]),
      .fault_o   (fault_vec[g])
    );
  end

  assign traffic_A   = lvl_vec[0];
  assign traffic_B   = lvl_vec[1];
  assign traffic_C   = lvl_vec[2];
  assign fault_A     = fault_vec[0];
  assign fault_B     = fault_vec[1];
  assign fault_C     = fault_vec[2];
  assign level_valid = valid_q;

endmodule

// File: tb/tb_traffic_density_estimator.sv
// Directed and randomized bench for traffic_density_estimator; a sample-history
// reference model checks every cycle, directed steps check the headline scenarios.
module tb_traffic_density_estimator;

  localparam int W  = 30;
  localparam int TM = 4;
  localparam int TH = 10;
  localparam int HY = 1;
  localparam int SC = 16;

  logic       clk = 1'b0;
  logic       reset, carA, carB, carC;
  logic [1:0] traffic_A, traffic_B, traffic_C;
  logic       level_valid, fault_A, fault_B, fault_C;

  logic       rst2, c2A;
  logic [1:0] t2A, t2B, t2C;
  logic       lv2, f2A, f2B, f2C;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_density_estimator #(
    .WINDOW_CYCLES(W), .TH_MED(TM), .TH_HIGH(TH), .HYST(HY), .STUCK_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .car_A(carA), .car_B(carB), .car_C(carC),
    .traffic_A(traffic_A), .traffic_B(traffic_B), .traffic_C(traffic_C),
    .level_valid(level_valid), .fault_A(fault_A), .fault_B(fault_B), .fault_C(fault_C)
  );

  // Long window with high thresholds: a wrapped count of 300 (44) would read LOW.
  traffic_density_estimator #(
    .WINDOW_CYCLES(700), .TH_MED(50), .TH_HIGH(100), .HYST(1), .STUCK_CYCLES(16)
  ) dut2 (
    .clk(clk), .reset(rst2), .car_A(c2A), .car_B(1'b0), .car_C(1'b0),
    .traffic_A(t2A), .traffic_B(t2B), .traffic_C(t2C),
    .level_valid(lv2), .fault_A(f2A), .fault_B(f2B), .fault_C(f2C)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          n;
  logic [31:0] hist [3];
  int          mcnt [3];
  logic [1:0]  mlvl [3];
  bit          mfault [3];
  bit          mvalid;
  logic [2:0]  cv;
  logic [1:0]  obs_lvl [3];
  logic        obs_flt [3];
  bit          fprev;

  function automatic logic [1:0] ref_level(input int c, input logic [1:0] cur, input bit f);
    if (f || c >= TH)                 return 2'b10;
    if (cur == 2'b10 && c >= TH - HY) return 2'b10;
    if (c >= TM)                      return 2'b01;
    if (cur != 2'b00 && c >= TM - HY) return 2'b01;
    return 2'b00;
  endfunction

  // Fault after clock n: the last SC+1 synchronized samples (ending 2 clocks ago) all high.
  function automatic bit stuck_now(input logic [31:0] h, input int cnt);
    if (cnt < SC + 3) return 1'b0;
    for (int j = 2; j <= SC + 2; j++) if (!h[j]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cv = {carC, carB, carA};
    if (!reset) begin
      n = 0;
      mvalid = 1'b0;
      for (int l = 0; l < 3; l++) begin
        hist[l] = '0; mcnt[l] = 0; mlvl[l] = 2'b00; mfault[l] = 1'b0;
      end
    end else begin
      n++;
      mvalid = (n % W == 0);
      for (int l = 0; l < 3; l++) begin
        hist[l] = {hist[l][30:0], cv[l]};
        fprev = mfault[l];
        if (n >= 4 && hist[l][2] && !hist[l][3] && mcnt[l] < 255) mcnt[l]++;
        if (mvalid) begin
          mlvl[l] = ref_level(mcnt[l], mlvl[l], fprev);
          mcnt[l] = 0;
        end
        mfault[l] = stuck_now(hist[l], n);
      end
    end
    #2;
    obs_lvl = '{traffic_A, traffic_B, traffic_C};
    obs_flt = '{fault_A, fault_B, fault_C};
    chk($sformatf("model valid n=%0d", n), level_valid, mvalid);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("model level lane%0d n=%0d", l, n), obs_lvl[l], mlvl[l]);
      chk($sformatf("model fault lane%0d n=%0d", l, n), obs_flt[l], mfault[l]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [2:0] v);
    @(negedge clk);
    {carC, carB, carA} = v;
  endtask

  task automatic pulses(input logic [2:0] mask, input int num);
    repeat (num) begin
      step(mask);
      step(3'b000);
    end
  endtask

  task automatic wait_strobe(input string tag);
    int k;
    k = 0;
    do begin
      @(posedge clk); #2; k++;
    end while (!level_valid && k < 80);
    chk({"strobe ", tag}, level_valid, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p, k;
    int dens [3];
    reset = 1'b0; carA = 0; carB = 0; carC = 0;
    rst2 = 1'b0; c2A = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset traffic_A", traffic_A, 2'b00);
    chk("reset level_valid", level_valid, 1'b0);
    chk("reset fault_A", fault_A, 1'b0);
    reset = 1'b1;

    // 5 pulses on A only -> MED / LOW / LOW
    pulses(3'b001, 5);
    wait_strobe("w1");
    chk("w1 traffic_A", traffic_A, 2'b01);
    chk("w1 traffic_B", traffic_B, 2'b00);
    chk("w1 traffic_C", traffic_C, 2'b00);

    // B: 12 -> HIGH, 9 -> holds HIGH, 2 -> straight to LOW
    pulses(3'b010, 12);
    wait_strobe("w2");
    chk("w2 traffic_B", traffic_B, 2'b10);
    pulses(3'b010, 9);
    wait_strobe("w3");
    chk("w3 traffic_B hyst", traffic_B, 2'b10);
    pulses(3'b010, 2);
    wait_strobe("w4");
    chk("w4 traffic_B drop", traffic_B, 2'b00);

    // C: 3 early pulses plus one whose edge lands on the window-end cycle
    pulses(3'b100, 3);
    repeat (21) step(3'b000);
    step(3'b100);
    step(3'b000);
    wait_strobe("w5");
    chk("w5 traffic_C edge at end", traffic_C, 2'b01);
    wait_strobe("w6");
    chk("w6 traffic_C cleared", traffic_C, 2'b00);

    // A held high for 20 cycles spanning the window end
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (i == 28) chk("stuck fault_A before", fault_A, 1'b0);
      if (i == 29) chk("stuck fault_A set", fault_A, 1'b1);
      if (i == 31) begin
        chk("stuck strobe", level_valid, 1'b1);
        chk("stuck traffic_A forced", traffic_A, 2'b10);
      end
      if (i == 32) chk("stuck fault_A hold", fault_A, 1'b1);
      if (i == 33) chk("stuck fault_A clear", fault_A, 1'b0);
      carA = (i >= 10 && i <= 29);
    end
    wait_strobe("w8");
    chk("w8 traffic_A released", traffic_A, 2'b00);

    // randomized traffic, varying density per lane every window
    for (int w = 0; w < 8; w++) begin
      for (int l = 0; l < 3; l++) dens[l] = $urandom_range(0, 95);
      repeat (W) step({ ($urandom_range(0, 99) < dens[2]),
                        ($urandom_range(0, 99) < dens[1]),
                        ($urandom_range(0, 99) < dens[0]) });
    end
    step(3'b000);
    wait_strobe("align");

    // simultaneous edges on all lanes
    pulses(3'b111, 6);
    wait_strobe("simul");
    chk("simul traffic_A", traffic_A, 2'b01);
    chk("simul traffic_B", traffic_B, 2'b01);
    chk("simul traffic_C", traffic_C, 2'b01);

    // reset mid-window with 7 counted, A left high through release
    pulses(3'b001, 7);
    step(3'b001);
    step(3'b001);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset traffic_A", traffic_A, 2'b00);
    chk("midreset traffic_B", traffic_B, 2'b00);
    chk("midreset traffic_C", traffic_C, 2'b00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (p = 1; p <= 40; p++) begin
      @(posedge clk); #2;
      if (level_valid) break;
      carA = (p < 5) || p == 8 || p == 10 || p == 12;
    end
    chk("postreset strobe clocks", 8'(p), 8'd30);
    chk("postreset traffic_A", traffic_A, 2'b00);

    // saturation: 300 pulses inside a 700-cycle window
    repeat (2) @(negedge clk);
    rst2 = 1'b1;
    repeat (2) @(negedge clk);
    repeat (300) begin
      @(negedge clk) c2A = 1'b1;
      @(negedge clk) c2A = 1'b0;
    end
    k = 0;
    do begin
      @(posedge clk); #2; k++;
    end while (!lv2 && k < 200);
    chk("sat strobe", lv2, 1'b1);
    chk("sat traffic_A", t2A, 2'b10);
    chk("sat traffic_B", t2B, 2'b00);
    chk("sat traffic_C", t2C, 2'b00);
    chk("sat fault_A", f2A, 1'b0);
    chk("sat fault_B", f2B, 1'b0);
    chk("sat fault_C", f2C, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
